// File: rtl/dc_dw_reader_pkg.sv
// Shared fixed-point helpers and FSM state type for the dc_dw weight updater.
package dc_dw_reader_pkg;

  localparam int unsigned gdo_size = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAPT,
    WRITE,
    DONE
  } state_t;

  // Signed add that clamps to the representable range instead of wrapping.
  function automatic logic signed [gdo_size-1:0] gdo_add(
    input logic signed [gdo_size-1:0] a,
    input logic signed [gdo_size-1:0] b
  );
    logic signed [gdo_size:0] s;
    s = {a[gdo_size-1], a} + {b[gdo_size-1], b};
    if (s[gdo_size] != s[gdo_size-1]) begin
      return s[gdo_size] ? {1'b1, {(gdo_size-1){1'b0}}} : {1'b0, {(gdo_size-1){1'b1}}};
    end
    return s[gdo_size-1:0];
  endfunction

  // old - (grad >>> shift); shift >= 1 keeps the negation in range.
  function automatic logic signed [gdo_size-1:0] gdo_scale_sub(
    input logic signed [gdo_size-1:0] old_w,
    input logic signed [gdo_size-1:0] grad,
    input int unsigned                shift
  );
    logic signed [gdo_size-1:0] g;
    g = grad >>> shift;
    return gdo_add(old_w, -g);
  endfunction

endpackage

// File: rtl/dc_dw_reader_if.sv
// Gradient request/stream and weight-memory bus seen by the dc_dw reader.
interface dc_dw_reader_if #(
  parameter int unsigned data_size = 16,
  parameter int unsigned size      = 3
);
  logic                        cal_dc_dw;
  logic [31:0]                 dc_dw_layer;
  logic [31:0]                 dc_dw_row;
  logic [data_size*size-1:0]   dc_dw_stream;
  logic [31:0]                 weight_layer;
  logic [31:0]                 weight_row;
  logic [data_size*size-1:0]   weight_rd_data;
  logic                        weight_we;
  logic [data_size*size-1:0]   weight_wr_data;

  modport master (
    output cal_dc_dw, dc_dw_layer, dc_dw_row,
    output weight_layer, weight_row, weight_we, weight_wr_data,
    input  dc_dw_stream, weight_rd_data
  );

  modport slave (
    input  cal_dc_dw, dc_dw_layer, dc_dw_row,
    input  weight_layer, weight_row, weight_we, weight_wr_data,
    output dc_dw_stream, weight_rd_data
  );
endinterface

// File: rtl/dc_dw_reader.sv
// Sweeps every (layer, row), fetches the gradient row and writes back
// weight - (gradient >>> lr_shift) with saturation.
module dc_dw_reader
  import dc_dw_reader_pkg::*;
#(
  parameter int unsigned data_size      = 16,
  parameter int unsigned size           = 3,
  parameter int unsigned max_layer_size = 4,
  parameter int unsigned lr_shift       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            last_layer,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_error,
  dc_dw_reader_if.master         bus
);

  // Element math uses the package helpers, which are gdo_size wide; data_size must match.
  state_t                    state, state_n;
  logic [31:0]               layer_cnt;
  logic [31:0]               row_cnt;
  logic [data_size*size-1:0] wr_data;
  logic [data_size*size-1:0] new_row;
  logic                      cfg_err_q;
  logic                      start_ok;
  logic                      last_row;

  assign start_ok = start && (last_layer < max_layer_size);
  assign last_row = (row_cnt >= size - 1);

  for (genvar i = 0; i < size; i++) begin : g_elem
    logic signed [data_size-1:0] grad;
    logic signed [data_size-1:0] old_w;
    assign grad  = bus.dc_dw_stream[(size-i)*data_size-1 -: data_size];
    assign old_w = bus.weight_rd_data[(size-i)*data_size-1 -: data_size];
    assign new_row[(size-i)*data_size-1 -: data_size] = gdo_scale_sub(old_w, grad, lr_shift);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state selection.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_ok) state_n = REQ;
      REQ:     state_n = CAPT;
      CAPT:    state_n = WRITE;
      WRITE:   state_n = (!last_row || layer_cnt != '0) ? REQ : DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Layer/row walk: layers count down, rows count up within a layer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      layer_cnt <= '0;
      row_cnt   <= '0;
    end else if (state == IDLE && start_ok) begin
      layer_cnt <= last_layer;
      row_cnt   <= '0;
    end else if (state == WRITE) begin
      if (!last_row) begin
        row_cnt <= row_cnt + 32'd1;
      end else if (layer_cnt != '0) begin
        row_cnt   <= '0;
        layer_cnt <= layer_cnt - 32'd1;
      end
    end
  end

  // Updated row is captured while the stack output and read data are valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              wr_data <= '0;
    else if (state == CAPT)  wr_data <= new_row;
  end

  // Rejected start flags a single-cycle configuration error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cfg_err_q <= 1'b0;
    else        cfg_err_q <= (state == IDLE) && start && !start_ok;
  end

  assign busy               = (state == REQ) || (state == CAPT) || (state == WRITE);
  assign done               = (state == DONE);
  assign cfg_error          = cfg_err_q;
  assign bus.cal_dc_dw      = (state == REQ);
  assign bus.weight_we      = (state == WRITE);
  assign bus.dc_dw_layer    = layer_cnt;
  assign bus.dc_dw_row      = row_cnt;
  assign bus.weight_layer   = layer_cnt;
  assign bus.weight_row     = row_cnt;
  assign bus.weight_wr_data = wr_data;

endmodule

// File: tb/tb_dc_dw_reader.sv
// Bench for dc_dw_reader: weight memory and gradient stack modelled as arrays.
module tb_dc_dw_reader;

  localparam int DW = 16;
  localparam int SZ = 3;
  localparam int ML = 4;
  localparam int SH = 4;
  localparam int RW = DW * SZ;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] last_layer;
  logic        busy, done, cfg_error;

  logic [RW-1:0] mem   [ML][SZ];
  logic [RW-1:0] grads [ML][SZ];

  int total = 0;
  int bad   = 0;

  dc_dw_reader_if #(.data_size(DW), .size(SZ)) bus ();

  dc_dw_reader #(
    .data_size(DW), .size(SZ), .max_layer_size(ML), .lr_shift(SH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .last_layer(last_layer),
    .busy(busy), .done(done), .cfg_error(cfg_error), .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.weight_rd_data = (bus.weight_layer < ML && bus.weight_row < SZ)
                            ? mem[bus.weight_layer[1:0]][bus.weight_row[1:0]] : '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: w - floor(g / 2^SH), clamped to 16-bit signed.
  function automatic logic [RW-1:0] ref_row(input logic [RW-1:0] old, input logic [RW-1:0] g);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < SZ; i++) begin
      logic [DW-1:0] os, gs;
      int o, gv, q, t;
      os = old[(SZ-i)*DW-1 -: DW];
      gs = g[(SZ-i)*DW-1 -: DW];
      o  = int'($signed(os));
      gv = int'($signed(gs));
      q  = gv / (1 << SH);
      if (gv < 0 && (gv % (1 << SH)) != 0) q = q - 1;
      t = o - q;
      if (t > 32767)  t = 32767;
      if (t < -32768) t = -32768;
      r[(SZ-i)*DW-1 -: DW] = t[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [RW-1:0] rnd_row();
    logic [63:0] tmp;
    tmp = {$urandom, $urandom};
    return tmp[RW-1:0];
  endfunction

  task automatic randomize_tables();
    for (int l = 0; l < ML; l++)
      for (int r = 0; r < SZ; r++) begin
        mem[l][r]   = rnd_row();
        grads[l][r] = rnd_row();
      end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_cfg"},   cfg_error, 0);
    check({tag, "_cal"},   bus.cal_dc_dw, 0);
    check({tag, "_we"},    bus.weight_we, 0);
    check({tag, "_dlay"},  bus.dc_dw_layer, 0);
    check({tag, "_drow"},  bus.dc_dw_row, 0);
    check({tag, "_wlay"},  bus.weight_layer, 0);
    check({tag, "_wrow"},  bus.weight_row, 0);
    check({tag, "_wdata"}, bus.weight_wr_data, 0);
  endtask

  // Full sweep with per-cycle schedule checks; optional stray start at cycle mid.
  task automatic run_sweep(input int last, input int mid);
    logic [RW-1:0] exp_w [ML][SZ];
    int n, j, jl, jr;
    bit pend;
    n = SZ * (last + 1);
    pend = 0;
    for (int l = 0; l < ML; l++)
      for (int r = 0; r < SZ; r++)
        exp_w[l][r] = ref_row(mem[l][r], grads[l][r]);
    last_layer = last;
    start = 1'b1;
    for (int k = 1; k <= 3*n + 4; k++) begin
      tick();
      start = 1'b0;
      if (mid != 0 && k == mid) begin
        start = 1'b1;
        last_layer = 7;
      end
      j  = (k - 1) / 3;
      jl = last - j / SZ;
      jr = j % SZ;
      bus.dc_dw_stream = pend ? grads[jl][jr] : rnd_row();
      pend = 0;
      check("busy", busy, (k <= 3*n));
      check("cal", bus.cal_dc_dw, (k <= 3*n && k % 3 == 1));
      check("we", bus.weight_we, (k <= 3*n && k % 3 == 0));
      check("done", done, (k == 3*n + 1));
      check("cfg_quiet", cfg_error, 0);
      if (k <= 3*n && k % 3 == 1) begin
        check("req_layer", bus.dc_dw_layer, jl);
        check("req_row", bus.dc_dw_row, jr);
        check("mem_layer", bus.weight_layer, jl);
        check("mem_row", bus.weight_row, jr);
        pend = 1;
      end
      if (k <= 3*n && k % 3 == 0) begin
        check("wr_data", bus.weight_wr_data, exp_w[jl][jr]);
        check("wr_layer", bus.weight_layer, jl);
        check("wr_row", bus.weight_row, jr);
        if (bus.weight_we) mem[jl][jr] = bus.weight_wr_data;
      end
    end
  endtask

  initial begin
    logic [RW-1:0] keep;
    reset = 1'b0;
    start = 1'b0;
    last_layer = '0;
    bus.dc_dw_stream = '0;
    for (int l = 0; l < ML; l++)
      for (int r = 0; r < SZ; r++) begin
        mem[l][r] = '0;
        grads[l][r] = '0;
      end

    // Reset while idle
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Single layer, constant data
    for (int r = 0; r < SZ; r++) begin
      mem[0][r]   = {16'd100, 16'd100, 16'd100};
      grads[0][r] = {16'd16, 16'd32, 16'hFFD0};
    end
    run_sweep(0, 0);
    for (int r = 0; r < SZ; r++) check("const_row", mem[0][r], 48'h0063_0062_0067);

    // Three layers, random data
    randomize_tables();
    run_sweep(2, 0);

    // Out-of-range last_layer is rejected
    for (int t = 0; t < 2; t++) begin
      last_layer = (t == 0) ? 32'd4 : 32'hFFFF_FFFF;
      start = 1'b1;
      for (int k = 1; k <= 5; k++) begin
        tick();
        start = 1'b0;
        check("cfg_err", cfg_error, (k == 1));
        check("cfg_busy", busy, 0);
        check("cfg_cal", bus.cal_dc_dw, 0);
        check("cfg_we", bus.weight_we, 0);
      end
    end

    // Saturation at both rails, and a zero gradient row
    randomize_tables();
    mem[0][0]   = {16'h7FFF, 16'h8000, 16'd5};
    grads[0][0] = {16'h8000, 16'h7FFF, 16'd0};
    grads[0][1] = '0;
    keep = mem[0][1];
    run_sweep(1, 0);
    check("sat_row", mem[0][0], {16'h7FFF, 16'h8000, 16'd5});
    check("zero_grad", mem[0][1], keep);

    // Stray start mid-sweep is ignored
    randomize_tables();
    run_sweep(1, 5);

    // Asynchronous reset during WRITE of row 1
    randomize_tables();
    last_layer = 1;
    start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      start = 1'b0;
    end
    check("pre_reset_we", bus.weight_we, 1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    check("rst_hold_we", bus.weight_we, 0);
    reset = 1'b1;
    tick();
    check_all_zero("post_rst");
    randomize_tables();
    run_sweep(0, 0);

    // Random sweeps
    for (int t = 0; t < 4; t++) begin
      randomize_tables();
      run_sweep(int'($urandom_range(0, ML - 1)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dc_dw_reader.md
Name: dc_dw_reader

Overview:
- Gradient-consuming end of the backprop stack's dc_dw request/stream interface.
- Walks every (layer, row) of the network after a backprop pass. Per step:
  - issues a cal_dc_dw request;
  - captures the returned dc_dw_stream one cycle later;
  - scales the gradient by the learning rate;
  - read-modify-writes the matching weight row in the external weight storage.
- Sits between the backprop stack and the dense-layer weight memory, under the training controller.

Parameters:
- data_size, 16, width of one signed fixed-point element.
- size, 3, elements per row and rows per layer.
- max_layer_size, 4, number of layer slots in the stack and in weight memory.
- lr_shift, 4, learning rate as 2^-lr_shift, applied by arithmetic right shift. Legal range 1..data_size-1.

Ports:
- clk, input, 1, sole clock; all state on posedge.
- reset, input, 1. Asynchronous, active-low reset.
- start, input, 1, one-cycle pulse that begins an update sweep.
- last_layer, input, 32, highest layer index to update; sampled on start.
- busy, output, 1, high from the cycle after an accepted start until done.
- done, output, 1, one-cycle pulse when the sweep completes.
- cfg_error, output, 1, one-cycle pulse when start is rejected because last_layer >= max_layer_size.
- cal_dc_dw, output, 1, request strobe to the backprop stack.
- dc_dw_layer, output, 32, requested layer.
- dc_dw_row, output, 32, requested row.
- dc_dw_stream, input, data_size*size, gradient row. Element i sits at bits [(size-i)*data_size-1 -: data_size].
- weight_layer, output, 32, weight memory address, layer.
- weight_row, output, 32, weight memory address, row.
- weight_rd_data, input, data_size*size, combinational read of the addressed row, same packing as dc_dw_stream.
- weight_we, output, 1, write strobe, one cycle.
- weight_wr_data, output, data_size*size, updated row, same packing.

Behaviour:
- Reset (async assert, sync release): state IDLE, layer/row counters 0, captured row zeroed.
  - All outputs 0, including busy, done, cfg_error, cal_dc_dw, weight_we, addresses and data.
  - Reset mid-sweep abandons the sweep; no further weight_we is issued.
- FSM has five states: IDLE, REQ, CAPT, WRITE, DONE.
- IDLE:
  - start with last_layer < max_layer_size: latch last_layer into layer counter, row counter = 0, go to REQ.
  - start with last_layer >= max_layer_size: cfg_error = 1 for one cycle, stay IDLE.
- REQ:
  - cal_dc_dw = 1 for exactly this cycle.
  - dc_dw_layer/weight_layer = layer counter; dc_dw_row/weight_row = row counter. Go to CAPT.
- CAPT:
  - Stack output is registered, so dc_dw_stream is valid now.
  - Per element: g = grad[i] >>> lr_shift, then new[i] = gdo_add(old[i], -g), with old from weight_rd_data.
  - Register new[] into weight_wr_data. Addresses held. Go to WRITE.
- WRITE:
  - weight_we = 1 for one cycle; addresses and weight_wr_data held.
  - Advance: if row < size-1, row++ and go to REQ.
  - Else if layer > 0: row = 0, layer--, go to REQ.
  - Else go to DONE.
- DONE: done = 1 for one cycle, busy = 0, go to IDLE.
- Ordering and latency:
  - Layers are swept from last_layer down to 0; rows go 0..size-1 within each layer.
  - Each row takes exactly 3 cycles.
  - Sweep latency from start to done = 3*size*(last_layer+1)+1 cycles.
- Outputs outside their active state:
  - cal_dc_dw and weight_we are 0.
  - Addresses hold their last value.
  - weight_wr_data holds its last value until the next CAPT.
- start while busy: ignored, with no error and no restart.
- Arithmetic:
  - All math is signed data_size with gdo_add saturation semantics.
  - Negation of the shifted value cannot overflow, because lr_shift >= 1.
  - A zero gradient leaves the weight bit-identical.
- last_layer = 0: a single-layer sweep of size rows.

Decomposition:
- Package gdo supplies gdo_add, gdo_mult and gdo_size; reuse gdo_add as-is.
- Add to the package:
  - an enum for the FSM states (IDLE, REQ, CAPT, WRITE, DONE);
  - a function gdo_scale_sub(old, grad, shift).
- No sub-module. Unpack/pack of the row buses uses generate wiring.

Test Plan:
- Reset while idle, then start with last_layer=0, stream constant {16,32,-48}, weights {100,100,100}, lr_shift=4:
  - cal_dc_dw pulses on cycles 1, 4, 7 with rows 0, 1, 2;
  - each write carries {99,98,103};
  - done pulses at cycle 10.
- last_layer=2: request layer sequence is 2,2,2,1,1,1,0,0,0 and busy stays high for exactly 27 cycles.
- start with last_layer=4 (max_layer_size=4): cfg_error pulses once, busy stays 0, no cal_dc_dw.
- Saturation case: weight 32767, grad -32768, lr_shift=1 -> written value is 32767 (saturated); zero grad -> weight unchanged.
- Second start pulsed mid-sweep is ignored: the sweep completes with the original count and only one done pulse.
- Reset deasserted low (asserted) during WRITE of row 1: all outputs go 0 asynchronously, no weight_we that cycle; after release the block is IDLE and accepts a new start.
